// File: rtl/mem_responder.sv
// mem_responder: 256-byte memory shared between a byte-stream loader and CPU read/write access.
module mem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        read,
  input  logic        write,
  output logic [7:0]  rdata,
  input  logic        ld_en,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_full,
  output logic        ld_done,
  output logic [8:0]  ld_count,
  output logic        oob_err
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2;
  logic [1:0] rst_sync;
  logic       rst_ok;
  logic [1:0] state;
  logic [7:0] ptr;
  logic [7:0] rdata_q;
  logic [7:0] mem [256];
  logic       in_range, cpu_ok, ld_acc, enter, leave, cpu_we, oob_hit;
  // Release is delayed two edges so nothing changes state on the first edge after rst rises.
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_ok   = rst_sync[1];
  assign in_range = addr[15:8] == 8'h00;
  assign cpu_ok   = state != LOAD;
  assign ld_ready = state == LOAD && !ld_full;
  assign ld_acc   = ld_valid && ld_ready;
  assign enter    = ld_en && state != LOAD;
  assign leave    = !ld_en && state == LOAD;
  assign cpu_we   = rst_ok && cpu_ok && write && in_range;
  assign oob_hit  = cpu_ok && (((read || write) && !in_range) || (read && write));
  assign rdata    = state == LOAD ? 8'h00 : rdata_q;
  always_ff @(posedge clk or negedge rst_ok)
    if (!rst_ok) begin
      state    <= IDLE;
      ptr      <= 8'h00;
      ld_count <= 9'd0;
      ld_full  <= 1'b0;
      ld_done  <= 1'b0;
      rdata_q  <= 8'h00;
      oob_err  <= 1'b0;
    end else begin
      state <= ld_en ? LOAD : (state == LOAD ? RUN : state);
      if (enter) begin
        ptr      <= 8'h00;
        ld_count <= 9'd0;
        ld_full  <= 1'b0;
        ld_done  <= 1'b0;
      end else if (ld_acc) begin
        ptr      <= ptr + 8'd1;
        ld_count <= ld_count + 9'd1;
        ld_full  <= ptr == 8'hff;
      end
      if (leave) ld_done <= 1'b1;
      rdata_q <= !cpu_ok ? 8'h00 : (read && !write) ? (in_range ? mem[addr[7:0]] : 8'h00) : rdata_q;
      if (oob_hit) oob_err <= 1'b1;
    end
  // Storage has no reset so loaded contents survive a reset pulse.
  always_ff @(posedge clk)
    if (ld_acc) mem[ptr] <= ld_data;
    else if (cpu_we) mem[addr[7:0]] <= wdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scenario tests of mem_responder against a byte-array reference model.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        read, write;
  logic [7:0]  rdata;
  logic        ld_en, ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready, ld_full, ld_done;
  logic [8:0]  ld_count;
  logic        oob_err;
  int          total = 0;
  int          passed = 0;
  logic [7:0]  model [256];

  mem_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read(read), .write(write),
    .rdata(rdata), .ld_en(ld_en), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_full(ld_full), .ld_done(ld_done), .ld_count(ld_count),
    .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    addr = a;
    read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr = a;
    wdata = d;
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick();
    total++; if (rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", rdata); else passed++;
    total++; if (ld_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ld_ready); else passed++;
    total++; if (ld_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", ld_full); else passed++;
    total++; if (ld_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", ld_done); else passed++;
    total++; if (ld_count !== 9'd0) $display("FAIL reset_count got=%0d exp=0", ld_count); else passed++;
    total++; if (oob_err !== 1'b0) $display("FAIL reset_oob got=%b exp=0", oob_err); else passed++;
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_sync;
    bit seen = 0;
    rst = 1'b0;
    tick();
    ld_en = 1'b1;
    rst = 1'b1;
    tick();
    total++; if (ld_ready !== 1'b0) $display("FAIL sync_first_edge ready got=%b exp=0", ld_ready); else passed++;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      seen = ld_ready === 1'b1;
    end
    total++; if (!seen) $display("FAIL sync_enter_load ready got=%b exp=1 within 6 cycles", ld_ready); else passed++;
    ld_en = 1'b0;
    tick();
    total++; if (ld_done !== 1'b1 || ld_count !== 9'd0) $display("FAIL sync_empty_session done=%b count=%0d exp 1/0", ld_done, ld_count); else passed++;
  endtask

  task automatic test_load_small;
    logic [7:0] b [3];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    ld_en = 1'b1;
    tick();
    total++; if (ld_ready !== 1'b1 || ld_done !== 1'b0 || ld_count !== 9'd0) $display("FAIL load_entry ready=%b done=%b count=%0d exp 1/0/0", ld_ready, ld_done, ld_count); else passed++;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data = b[i];
      model[i] = b[i];
      tick();
    end
    ld_valid = 1'b0;
    total++; if (rdata !== 8'h00) $display("FAIL load_rdata_zero got=%h exp=00", rdata); else passed++;
    ld_en = 1'b0;
    tick();
    total++; if (ld_count !== 9'd3 || ld_done !== 1'b1) $display("FAIL load3 count=%0d done=%b exp 3/1", ld_count, ld_done); else passed++;
    cpu_read(16'h0001);
    total++; if (rdata !== 8'h22) $display("FAIL load3_read got=%h exp=22", rdata); else passed++;
    repeat (3) begin
      int n = 0;
      int len = $urandom_range(5, 30);
      int idx;
      ld_en = 1'b1;
      tick();
      for (int c = 0; c < len; c++) begin
        ld_valid = 1'($urandom % 2);
        ld_data = 8'($urandom);
        if (ld_valid) begin
          model[n] = ld_data;
          n++;
        end
        tick();
      end
      ld_valid = 1'b0;
      ld_en = 1'b0;
      tick();
      total++; if (ld_count !== 9'(n)) $display("FAIL rand_load_count got=%0d exp=%0d", ld_count, n); else passed++;
      if (n > 0) begin
        idx = $urandom_range(0, n - 1);
        cpu_read(16'(idx));
        total++; if (rdata !== model[idx]) $display("FAIL rand_load_read addr=%0d got=%h exp=%h", idx, rdata, model[idx]); else passed++;
      end
    end
  endtask

  task automatic test_full;
    ld_en = 1'b1;
    tick();
    for (int k = 0; k < 260; k++) begin
      ld_valid = 1'b1;
      ld_data = 8'($urandom);
      if (k < 256) model[k] = ld_data;
      tick();
    end
    total++; if (ld_full !== 1'b1 || ld_count !== 9'd256 || ld_ready !== 1'b0) $display("FAIL full_flags full=%b count=%0d ready=%b exp 1/256/0", ld_full, ld_count, ld_ready); else passed++;
    ld_valid = 1'b0;
    ld_en = 1'b0;
    tick();
    total++; if (ld_done !== 1'b1 || ld_count !== 9'd256) $display("FAIL full_done done=%b count=%0d exp 1/256", ld_done, ld_count); else passed++;
    cpu_read(16'h0000);
    total++; if (rdata !== model[0]) $display("FAIL full_first_byte got=%h exp=%h", rdata, model[0]); else passed++;
    repeat (8) begin
      int a = $urandom_range(0, 255);
      cpu_read(16'(a));
      total++; if (rdata !== model[a]) $display("FAIL full_read addr=%0d got=%h exp=%h", a, rdata, model[a]); else passed++;
    end
  endtask

  task automatic test_cpu;
    total++; if (oob_err !== 1'b0) $display("FAIL cpu_oob_initial got=%b exp=0", oob_err); else passed++;
    cpu_write(16'h0040, 8'hA5);
    model[8'h40] = 8'hA5;
    cpu_read(16'h0040);
    total++; if (rdata !== 8'hA5) $display("FAIL cpu_raw got=%h exp=a5", rdata); else passed++;
    repeat (30) begin
      int a = $urandom_range(0, 255);
      if ($urandom % 2) begin
        logic [7:0] d = 8'($urandom);
        cpu_write(16'(a), d);
        model[a] = d;
      end else begin
        cpu_read(16'(a));
        total++; if (rdata !== model[a]) $display("FAIL cpu_rand_read addr=%0d got=%h exp=%h", a, rdata, model[a]); else passed++;
      end
    end
    tick();
    total++; if (rdata !== model[addr[7:0]] && 0) $display(""); 
    total--;
    total++; if (oob_err !== 1'b0) $display("FAIL cpu_oob_after_inrange got=%b exp=0", oob_err); else passed++;
    cpu_read(16'h0140);
    total++; if (rdata !== 8'h00 || oob_err !== 1'b1) $display("FAIL cpu_oob_read rdata=%h oob=%b exp 00/1", rdata, oob_err); else passed++;
    cpu_write(16'h0240, 8'h77);
    cpu_read(16'h0040);
    total++; if (rdata !== model[8'h40]) $display("FAIL cpu_oob_write_discard got=%h exp=%h", rdata, model[8'h40]); else passed++;
  endtask

  task automatic test_rw_both;
    logic [7:0] prev;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (oob_err !== 1'b0) $display("FAIL rw_oob_cleared got=%b exp=0", oob_err); else passed++;
    cpu_read(16'h0033);
    total++; if (rdata !== model[8'h33]) $display("FAIL rw_retained addr=33 got=%h exp=%h", rdata, model[8'h33]); else passed++;
    prev = model[8'h33];
    addr = 16'h0010;
    wdata = 8'h5A;
    read = 1'b1;
    write = 1'b1;
    tick();
    read = 1'b0;
    write = 1'b0;
    model[8'h10] = 8'h5A;
    total++; if (rdata !== prev || oob_err !== 1'b1) $display("FAIL rw_both rdata=%h oob=%b exp %h/1", rdata, oob_err, prev); else passed++;
    cpu_read(16'h0010);
    total++; if (rdata !== 8'h5A) $display("FAIL rw_both_stored got=%h exp=5a", rdata); else passed++;
  endtask

  task automatic test_load_blocks_cpu;
    ld_en = 1'b1;
    tick();
    addr = 16'h0020;
    wdata = ~model[8'h20];
    write = 1'b1;
    repeat (2) tick();
    write = 1'b0;
    total++; if (rdata !== 8'h00) $display("FAIL load_cpu_rdata got=%h exp=00", rdata); else passed++;
    cpu_read(16'h0020);
    total++; if (rdata !== 8'h00) $display("FAIL load_cpu_read got=%h exp=00", rdata); else passed++;
    ld_en = 1'b0;
    tick();
    total++; if (ld_count !== 9'd0 || ld_done !== 1'b1) $display("FAIL load_cpu_session count=%0d done=%b exp 0/1", ld_count, ld_done); else passed++;
    cpu_read(16'h0020);
    total++; if (rdata !== model[8'h20]) $display("FAIL load_cpu_unchanged got=%h exp=%h", rdata, model[8'h20]); else passed++;
  endtask

  task automatic test_exit_accept;
    logic [7:0] d = 8'($urandom);
    ld_en = 1'b1;
    tick();
    ld_valid = 1'b1;
    ld_data = d;
    ld_en = 1'b0;
    tick();
    ld_valid = 1'b0;
    model[0] = d;
    total++; if (ld_count !== 9'd1 || ld_done !== 1'b1 || ld_ready !== 1'b0) $display("FAIL exit_accept count=%0d done=%b ready=%b exp 1/1/0", ld_count, ld_done, ld_ready); else passed++;
    cpu_read(16'h0000);
    total++; if (rdata !== d) $display("FAIL exit_accept_stored got=%h exp=%h", rdata, d); else passed++;
  endtask

  task automatic test_reset_mid_load;
    ld_en = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data = 8'($urandom);
      model[i] = ld_data;
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b0;
    #1;
    ld_en = 1'b0;
    total++; if (ld_count !== 9'd0 || ld_done !== 1'b0 || ld_ready !== 1'b0 || ld_full !== 1'b0) $display("FAIL midload_reset count=%0d done=%b ready=%b full=%b exp 0/0/0/0", ld_count, ld_done, ld_ready, ld_full); else passed++;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (ld_ready !== 1'b0 || ld_done !== 1'b0) $display("FAIL midload_idle ready=%b done=%b exp 0/0", ld_ready, ld_done); else passed++;
    cpu_read(16'h0001);
    total++; if (rdata !== model[1]) $display("FAIL midload_retained got=%h exp=%h", rdata, model[1]); else passed++;
  endtask

  initial begin
    rst = 1'b0;
    addr = 16'h0000;
    wdata = 8'h00;
    read = 1'b0;
    write = 1'b0;
    ld_en = 1'b0;
    ld_valid = 1'b0;
    ld_data = 8'h00;
    test_reset();
    test_reset_sync();
    test_load_small();
    test_full();
    test_cpu();
    test_rw_both();
    test_load_blocks_cpu();
    test_exit_accept();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
